sync_fifo_lvl: RTL
==================

Name: sync_fifo_lvl

Overview:
Single-clock, parametrised FIFO that generalises the team's dual-clock FIFO for same-domain buffering between the readout FSM, I2C register bank and serialiser.
- Adds an occupancy level output, programmable almost-full and almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags.
- Supports fallthrough and registered-output read modes.

Parameters:
WIDTH, 30, data word width in bits.
PTR_WIDTH, 3, address width; DEPTH = 2**PTR_WIDTH words.
FALLTROUGH, 1, 1: head word is presented combinationally on data_out; 0: data_out is registered on an accepted read.

Ports:
clk  in  1  clock, rising-edge.
res_n  in  1  reset, asynchronous, active-low.
data_in  in  WIDTH  write data.
wr  in  1  write request.
rd  in  1  read request.
flush  in  1  synchronous clear of contents.
err_clr  in  1  clears sticky error flags.
af_thresh  in  PTR_WIDTH+1  almost-full threshold.
ae_thresh  in  PTR_WIDTH+1  almost-empty threshold.
data_out  out  WIDTH  read data.
full  out  1  level == DEPTH.
empty  out  1  level == 0.
almost_full  out  1  level >= af_thresh.
almost_empty  out  1  level <= ae_thresh.
level  out  PTR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky: write attempted while full.
underflow  out  1  sticky: read attempted while empty.
peak_level  out  PTR_WIDTH+1  high-watermark (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset res_n is asynchronous, active-low.
- Reset values: wptr = rptr = level = 0; empty = 1; full = 0; almost_empty = 1; almost_full = (af_thresh == 0); overflow = underflow = 0; data_out = 0 when FALLTROUGH = 0; peak_level = 0. Memory is not reset.
- Pointers: binary, PTR_WIDTH bits, wrap modulo DEPTH. level is a separate registered counter, PTR_WIDTH+1 bits.
- Acceptance (evaluated on the registered state at the clock edge):
  - wr_acc = wr & ~full
  - rd_acc = rd & ~empty
- Level update: level += wr_acc − rd_acc. Both accepted: level unchanged, both pointers advance.
- Write while full with rd high: the read is accepted and the write is rejected. Level drops to DEPTH−1 and overflow sets.
- Read while empty with wr high: the write is accepted and the read is rejected. underflow sets; data_out is unchanged in registered mode.
- Status flags: full, empty, almost_full and almost_empty are combinational from the registered level and the threshold ports. They are valid in the cycle after the edge that changed level.
- Write latency: a word written at edge k is readable from the cycle after k (empty = 0).
  - FALLTROUGH = 1: data_out = mem[rptr] at all times; it is undefined while empty.
  - FALLTROUGH = 0: on rd_acc, data_out <= mem[rptr] at the edge; it holds otherwise.
- Flush: highest priority at the edge. wptr = rptr = level = 0, and wr/rd in that cycle are ignored. Error flags and memory are untouched; peak_level is cleared.
- Errors: overflow is set on wr & full and underflow on rd & empty. Both are held until err_clr or reset. If err_clr and a new error occur in the same cycle, the flag stays set (set wins).
- Thresholds: may change at any time; the flags follow combinationally. af_thresh > DEPTH means almost_full is never asserted.
- Mid-operation reset: all state returns immediately to reset values.

Optional Feature:
- Macro: SYNC_FIFO_PEAK_EN.
- Defined: peak_level registers max(level) since reset or flush. It updates one cycle after level, i.e. peak_level <= max(peak_level, level).
- Not defined: peak_level is tied to 0 and no register is inferred. The port is present in both builds.

Decomposition:
- fifo_pkg holds:
  - a fifo_status_t struct {full, empty, almost_full, almost_empty, overflow, underflow};
  - a function clog2-free depth helper DEPTH_OF(ptr_width).
  Shared with async_fifo users.
- Sub-module fifo_mem: simple dual-port array (one write port, one read port). It has a registered/combinational read select matching FALLTROUGH, so an SRAM macro can replace it later.

Test Plan:
- Reset, then write 8 words 0x1..0x8 with DEPTH = 8 → level steps 1..8; full = 1 after the 8th edge; almost_full at level 6 with af_thresh = 6.
- Full FIFO, wr = rd = 1 for one cycle → level = 7; data_out advances to 0x2 (fallthrough); overflow = 1. Then err_clr → overflow = 0.
- Empty FIFO, rd = 1 → underflow = 1 and level stays 0. Same cycle wr = 1 with data 0xAB → level = 1 and data_out = 0xAB (fallthrough).
- Write 3 and read 3 simultaneously across pointer wrap (start at rptr = wptr = 6) → data order preserved, level constant, pointers wrap to 1.
- Level 5, flush = 1 with wr = 1 → level = 0, empty = 1, overflow unchanged. Peak build: peak_level = 5 before flush, 0 after.
- FALLTROUGH = 0: write 0x3 then 0x4, pulse rd twice → data_out = 0x3 the cycle after the 1st edge and 0x4 the cycle after the 2nd. Assert res_n low mid-sequence → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fifo_pkg.sv
// Types and helpers shared by the single-clock and dual-clock FIFO families.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int DEPTH_OF(input int ptr_width);
        return 1 << ptr_width;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one write port, one read port whose output is either
// combinational (FALLTROUGH != 0) or a register loaded on re. Swappable for an SRAM macro.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 30,
    parameter int PTR_WIDTH  = 3,
    parameter int FALLTROUGH = 1
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 we,
    input  logic [PTR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [PTR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    localparam int DEPTH = DEPTH_OF(PTR_WIDTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    // Storage is deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rd_q <= '0;
        end else if (re) begin
            rd_q <= mem[raddr];
        end
    end

    assign rdata = (FALLTROUGH != 0) ? mem[raddr] : rd_q;

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with occupancy level, programmable almost-full/empty, flush and
// sticky error flags. Define SYNC_FIFO_PEAK_EN to build the peak_level high-watermark.
module sync_fifo_lvl
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 30,
    parameter int PTR_WIDTH  = 3,
    parameter int FALLTROUGH = 1
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 wr,
    input  logic                 rd,
    input  logic                 flush,
    input  logic                 err_clr,
    input  logic [PTR_WIDTH:0]   af_thresh,
    input  logic [PTR_WIDTH:0]   ae_thresh,
    output logic [WIDTH-1:0]     data_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   level,
    output logic                 overflow,
    output logic                 underflow,
    output logic [PTR_WIDTH:0]   peak_level
);

    localparam int                 DEPTH     = DEPTH_OF(PTR_WIDTH);
    localparam logic [PTR_WIDTH:0] DEPTH_LVL = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] LVL_ONE   = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

    logic [PTR_WIDTH-1:0] wptr;
    logic [PTR_WIDTH-1:0] rptr;
    logic [PTR_WIDTH:0]   lvl_q;
    logic                 ovf_q;
    logic                 unf_q;
    logic                 wr_acc;
    logic                 rd_acc;
    fifo_status_t         status;

    always_comb begin
        status              = '0;
        status.full         = (lvl_q == DEPTH_LVL);
        status.empty        = (lvl_q == '0);
        status.almost_full  = (lvl_q >= af_thresh);
        status.almost_empty = (lvl_q <= ae_thresh);
        status.overflow     = ovf_q;
        status.underflow    = unf_q;
    end

    // Handshake: wr/rd are requests sampled at the rising edge; a write is taken only
    // when not full, a read only when not empty, and flush at the same edge drops both.
    assign wr_acc = wr & ~status.full  & ~flush;
    assign rd_acc = rd & ~status.empty & ~flush;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wptr  <= '0;
            rptr  <= '0;
            lvl_q <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            lvl_q <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + PTR_ONE;
            if (rd_acc) rptr <= rptr + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   lvl_q <= lvl_q + LVL_ONE;
                2'b01:   lvl_q <= lvl_q - LVL_ONE;
                default: lvl_q <= lvl_q;
            endcase
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (wr & status.full  & ~flush) | (ovf_q & ~err_clr);
            unf_q <= (rd & status.empty & ~flush) | (unf_q & ~err_clr);
        end
    end

    fifo_mem #(
        .WIDTH      (WIDTH),
        .PTR_WIDTH  (PTR_WIDTH),
        .FALLTROUGH (FALLTROUGH)
    ) u_mem (
        .clk   (clk),
        .res_n (res_n),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (data_in),
        .re    (rd_acc),
        .raddr (rptr),
        .rdata (data_out)
    );

`ifdef SYNC_FIFO_PEAK_EN
    logic [PTR_WIDTH:0] peak_q;

    // Follows level one edge behind, so it sees every registered occupancy value.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            peak_q <= '0;
        end else if (flush) begin
            peak_q <= '0;
        end else if (lvl_q > peak_q) begin
            peak_q <= lvl_q;
        end
    end

    assign peak_level = peak_q;
`else
    assign peak_level = '0;
`endif

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;
    assign level        = lvl_q;

endmodule
